sakebi_rmii_rx_axis: RTL and testbench
======================================

SAKEBI_RMII_RX_AXIS -- requirements
Module: sakebi_rmii_rx_axis

Interface
REQ-001 Parameter DATA_WIDTH, default 8, sets the AXIS data width; it SHALL be 8, 16 or 32 (1/2/4 bytes per beat).
REQ-002 Parameter FIFO_DEPTH, default 16, sets the number of beats in the output FIFO; it SHALL be a power of 2 and at least 4.
REQ-003 Parameter CHECK_FCS, default 1, SHALL enable the CRC-32 check when 1; when 0, no FCS error is ever flagged.
REQ-004 i_rmii_REF_CLK  in  1  sole 50 MHz clock; all logic SHALL be rising-edge triggered.
REQ-005 i_axis_ARESETn  in  1  asynchronous active-low reset.
REQ-006 i_rmii_CRS_DV  in  1  carrier sense / data valid.
REQ-007 i_rmii_RXD  in  2  receive dibit.
REQ-008 o_axis_TVALID  out  1  beat valid.
REQ-009 i_axis_TREADY  in  1  sink ready.
REQ-010 o_axis_TDATA  out  DATA_WIDTH  frame bytes, first byte in bits [7:0].
REQ-011 o_axis_TKEEP  out  DATA_WIDTH/8  byte-valid mask.
REQ-012 o_axis_TLAST  out  1  last beat of frame.
REQ-013 o_axis_TUSER  out  1  frame-error flag, meaningful only when TLAST=1.
REQ-014 o_rx_frames  out  16  count of frames terminated with TUSER=0; saturates at 0xFFFF.
REQ-015 o_rx_errors  out  16  count of frames terminated with TUSER=1; saturates at 0xFFFF.

Function
REQ-016 CRS_DV and RXD SHALL be registered once before any use; all rules below refer to the registered values.
REQ-017 The FSM SHALL have the states IDLE, PREAMBLE, DATA and DROP.
REQ-018 IDLE: CRS_DV=1 SHALL move the FSM to PREAMBLE.
REQ-019 PREAMBLE: RXD 00 or 01 stays; 11 after at least one 01 moves to DATA; 11 with no prior 01, or 10, moves to DROP; CRS_DV=0 moves to IDLE; none of these cases produces output.
REQ-020 DATA: dibits SHALL be assembled LSB-first, so the first dibit of each byte goes to bits [1:0].
REQ-021 Bytes SHALL pack into beats in arrival order.
REQ-022 A completed beat SHALL be held until the next byte arrives or the frame ends, so that TLAST is always written with the final beat.
REQ-023 End of frame is CRS_DV=0 in DATA; the FSM then writes the final beat and returns to IDLE.
REQ-024 The final beat SHALL have TLAST=1 and a TKEEP of contiguous ones from bit 0 covering the valid bytes; non-final beats SHALL have TKEEP all ones.
REQ-025 Unused bytes of a final beat SHALL read 0x00.
REQ-026 TUSER=1 on the final beat if any of these holds: (a) the dibit count is not a multiple of 4, in which case the partial byte is discarded; (b) CHECK_FCS=1 and the CRC register (init 0xFFFFFFFF, reflected polynomial 0xEDB88320, run over every byte after the SFD including the FCS) is not 0xDEBB20E3; (c) an overflow occurred (REQ-029).
REQ-027 FCS bytes SHALL be forwarded unchanged.
REQ-028 A frame ending with zero whole bytes after the SFD SHALL emit nothing and SHALL NOT be counted.
REQ-029 FIFO full when a beat must be written: the beat is discarded, the FSM enters DROP, and a terminating beat (TKEEP=0, TDATA=0, TLAST=1, TUSER=1) is written on the first cycle the FIFO is not full, even if CRS_DV is still high.
REQ-030 DROP: the FSM remains in DROP until CRS_DV=0, then moves to IDLE; a frame dropped from PREAMBLE emits nothing and is not counted.
REQ-031 The AXIS output SHALL be driven directly from the FIFO head.
REQ-032 While TVALID=1 and TREADY=0, TDATA, TKEEP, TLAST and TUSER SHALL be held stable.
REQ-033 A FIFO write and read in the same cycle SHALL both occur when the FIFO is full and TREADY=1.
REQ-034 A FIFO write and read in the same cycle SHALL both occur when the FIFO is empty: the read is a no-op and the write lands.
REQ-035 With the FIFO empty and TREADY=1, TVALID for the TLAST beat SHALL assert within 4 cycles of the registered CRS_DV=0.
REQ-036 A counter increments in the cycle its terminating beat is written to the FIFO.

Reset
REQ-037 Asserting i_axis_ARESETn low SHALL immediately force: FSM to IDLE, FIFO empty, TVALID=0, TDATA=0, TKEEP=0, TLAST=0, TUSER=0, counters=0.
REQ-038 A frame in progress at reset SHALL be lost entirely.
REQ-039 After deassertion, if CRS_DV is already high, the block SHALL enter PREAMBLE and lock onto the next valid 01…11 sequence.
REQ-040 If the frame in progress at deassertion is already past its SFD, the block SHALL enter DROP.

Verification
REQ-041 DATA_WIDTH=8, valid 64-byte frame with correct FCS, TREADY=1 -> 64 beats with TKEEP=1, TLAST only on beat 64, TUSER=0, o_rx_frames=1.
REQ-042 DATA_WIDTH=32, 65-byte frame -> 17 beats; the last has TKEEP=0001, TLAST=1, and bits [31:8]=0.
REQ-043 Same frame with one payload bit flipped -> identical beats, except the final beat has TUSER=1; o_rx_errors=1.
REQ-044 Frame ending after 3 extra dibits -> partial byte dropped, TUSER=1 on the last whole-byte beat.
REQ-045 FIFO_DEPTH=4, TREADY=0 throughout a 20-byte frame -> 4 beats held, then one TKEEP=0/TLAST=1/TUSER=1 beat after TREADY rises; the next frame is received cleanly.
REQ-046 Reset asserted mid-DATA, then released while CRS_DV=1 -> no output for the cut frame; the following frame is delivered normally.

Source files
------------

// File: rtl/sakebi_rmii_rx_axis.sv
// sakebi_rmii_rx_axis
//   RMII receive path to AXI-Stream. Strips preamble/SFD, packs frame bytes
//   LSB-first into DATA_WIDTH beats, checks the CRC-32 FCS and buffers beats
//   in a FIFO_DEPTH-entry FIFO whose head drives the AXIS output directly.
// Ports:
//   i_rmii_REF_CLK  50 MHz clock (rising edge only)
//   i_axis_ARESETn  asynchronous active-low reset
//   i_rmii_CRS_DV   carrier sense / data valid
//   i_rmii_RXD      receive dibit
//   o_axis_T*       AXIS master (TUSER = frame error, valid with TLAST)
//   i_axis_TREADY   AXIS sink ready
//   o_rx_frames     saturating count of good frames
//   o_rx_errors     saturating count of errored frames
module sakebi_rmii_rx_axis #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter bit CHECK_FCS  = 1'b1
) (
    input  logic                    i_rmii_REF_CLK,
    input  logic                    i_axis_ARESETn,
    input  logic                    i_rmii_CRS_DV,
    input  logic [1:0]              i_rmii_RXD,
    output logic                    o_axis_TVALID,
    input  logic                    i_axis_TREADY,
    output logic [DATA_WIDTH-1:0]   o_axis_TDATA,
    output logic [DATA_WIDTH/8-1:0] o_axis_TKEEP,
    output logic                    o_axis_TLAST,
    output logic                    o_axis_TUSER,
    output logic [15:0]             o_rx_frames,
    output logic [15:0]             o_rx_errors
);

    localparam int KW  = DATA_WIDTH / 8;
    localparam int NBW = $clog2(KW) + 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int EW  = DATA_WIDTH + KW + 2;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

    state_t                state_q, state_d;
    logic                  crs_q;
    logic [1:0]            rxd_q;
    logic                  saw01_q, saw01_d;
    logic [1:0]            dib_q, dib_d;
    logic [7:0]            sr_q, sr_d;
    logic [31:0]           crc_q, crc_d;
    logic [DATA_WIDTH-1:0] beat_q, beat_d;
    logic [NBW-1:0]        nb_q, nb_d;
    logic                  term_q, term_d;

    logic [EW-1:0]         mem_q [FIFO_DEPTH];
    logic [AW:0]           wp_q, rp_q;
    logic                  full, empty, can_wr, rd_en;
    logic                  wr_en, wr_last, wr_user;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [KW-1:0]         wr_keep;
    logic [7:0]            new_byte;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int unsigned i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    assign full   = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign empty  = (wp_q == rp_q);
    // A full FIFO still accepts a write when the head is leaving this cycle.
    assign can_wr = !full || i_axis_TREADY;
    assign rd_en  = !empty && i_axis_TREADY;

    assign o_axis_TVALID = !empty;
    assign {o_axis_TLAST, o_axis_TUSER, o_axis_TKEEP, o_axis_TDATA} = mem_q[rp_q[AW-1:0]];

    // Byte completed by the current dibit (first dibit ends up in [1:0]).
    assign new_byte = {rxd_q, sr_q[7:2]};

    always_comb begin
        state_d = state_q;
        saw01_d = saw01_q;
        dib_d   = dib_q;
        sr_d    = sr_q;
        crc_d   = crc_q;
        beat_d  = beat_q;
        nb_d    = nb_q;
        term_d  = term_q;
        wr_en   = 1'b0;
        wr_data = beat_q;
        wr_keep = '1;
        wr_last = 1'b0;
        wr_user = 1'b0;
        case (state_q)
            IDLE: begin
                saw01_d = 1'b0;
                if (crs_q) state_d = PREAMBLE;
            end
            PREAMBLE: begin
                if (!crs_q) begin
                    state_d = IDLE;
                end else begin
                    case (rxd_q)
                        2'b01: saw01_d = 1'b1;
                        2'b10: state_d = DROP;
                        2'b11: begin
                            if (saw01_q) begin
                                state_d = DATA;
                                dib_d   = '0;
                                crc_d   = '1;
                                beat_d  = '0;
                                nb_d    = '0;
                            end else begin
                                state_d = DROP;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            DATA: begin
                if (!crs_q) begin
                    if (nb_q != '0) begin
                        for (int unsigned b = 0; b < KW; b++)
                            wr_keep[b] = (NBW'(b) < nb_q);
                        wr_last = 1'b1;
                        wr_user = (dib_q != '0) || (CHECK_FCS && (crc_q != CRC_RESIDUE));
                        if (can_wr) begin
                            wr_en   = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = DROP;
                            term_d  = 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    sr_d  = new_byte;
                    dib_d = dib_q + 2'd1;
                    if (dib_q == 2'd3) begin
                        crc_d = crc_byte(crc_q, new_byte);
                        // A full beat is only released once another byte proves it is not last.
                        if (nb_q == NBW'(KW)) begin
                            if (can_wr) begin
                                wr_en       = 1'b1;
                                beat_d      = '0;
                                beat_d[7:0] = new_byte;
                                nb_d        = NBW'(1);
                            end else begin
                                state_d = DROP;
                                term_d  = 1'b1;
                            end
                        end else begin
                            for (int unsigned b = 0; b < KW; b++)
                                if (nb_q == NBW'(b)) beat_d[8*b +: 8] = new_byte;
                            nb_d = nb_q + 1'b1;
                        end
                    end
                end
            end
            DROP: begin
                if (term_q) begin
                    wr_data = '0;
                    wr_keep = '0;
                    wr_last = 1'b1;
                    wr_user = 1'b1;
                    if (can_wr) begin
                        wr_en  = 1'b1;
                        term_d = 1'b0;
                    end
                end
                if (!crs_q && (!term_q || can_wr)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_rmii_REF_CLK or negedge i_axis_ARESETn) begin
        if (!i_axis_ARESETn) begin
            crs_q   <= 1'b0;
            rxd_q   <= '0;
            state_q <= IDLE;
            saw01_q <= 1'b0;
            dib_q   <= '0;
            sr_q    <= '0;
            crc_q   <= '1;
            beat_q  <= '0;
            nb_q    <= '0;
            term_q  <= 1'b0;
        end else begin
            crs_q   <= i_rmii_CRS_DV;
            rxd_q   <= i_rmii_RXD;
            state_q <= state_d;
            saw01_q <= saw01_d;
            dib_q   <= dib_d;
            sr_q    <= sr_d;
            crc_q   <= crc_d;
            beat_q  <= beat_d;
            nb_q    <= nb_d;
            term_q  <= term_d;
        end
    end

    always_ff @(posedge i_rmii_REF_CLK or negedge i_axis_ARESETn) begin
        if (!i_axis_ARESETn) begin
            wp_q <= '0;
            rp_q <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wp_q[AW-1:0]] <= {wr_last, wr_user, wr_keep, wr_data};
                wp_q <= wp_q + 1'b1;
            end
            if (rd_en) rp_q <= rp_q + 1'b1;
        end
    end

    always_ff @(posedge i_rmii_REF_CLK or negedge i_axis_ARESETn) begin
        if (!i_axis_ARESETn) begin
            o_rx_frames <= '0;
            o_rx_errors <= '0;
        end else if (wr_en && wr_last) begin
            if (wr_user) begin
                if (o_rx_errors != 16'hFFFF) o_rx_errors <= o_rx_errors + 16'd1;
            end else begin
                if (o_rx_frames != 16'hFFFF) o_rx_frames <= o_rx_frames + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_sakebi_rmii_rx_axis.sv
// Testbench for sakebi_rmii_rx_axis: three instances (8-bit, 32-bit, 8-bit with
// a 4-deep FIFO) see the same RMII stimulus; captured beats are compared with
// beats derived from the frame bytes by a behavioural model.
module tb_sakebi_rmii_rx_axis;

    typedef struct packed {
        logic        last;
        logic        user;
        logic [3:0]  keep;
        logic [31:0] data;
    } beat_t;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       rst_n;
    logic       crs;
    logic [1:0] rxd;
    logic       rdy8, rdy32, rdys;

    logic        v8, l8, u8;   logic [7:0]  d8;  logic [0:0] k8;  logic [15:0] f8, e8;
    logic        v32, l32, u32; logic [31:0] d32; logic [3:0] k32; logic [15:0] f32, e32;
    logic        vs, ls, us;   logic [7:0]  ds;  logic [0:0] ks;  logic [15:0] fs, es;

    sakebi_rmii_rx_axis #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .CHECK_FCS(1'b1)) dut8 (
        .i_rmii_REF_CLK(clk), .i_axis_ARESETn(rst_n), .i_rmii_CRS_DV(crs), .i_rmii_RXD(rxd),
        .o_axis_TVALID(v8), .i_axis_TREADY(rdy8), .o_axis_TDATA(d8), .o_axis_TKEEP(k8),
        .o_axis_TLAST(l8), .o_axis_TUSER(u8), .o_rx_frames(f8), .o_rx_errors(e8));

    sakebi_rmii_rx_axis #(.DATA_WIDTH(32), .FIFO_DEPTH(16), .CHECK_FCS(1'b1)) dut32 (
        .i_rmii_REF_CLK(clk), .i_axis_ARESETn(rst_n), .i_rmii_CRS_DV(crs), .i_rmii_RXD(rxd),
        .o_axis_TVALID(v32), .i_axis_TREADY(rdy32), .o_axis_TDATA(d32), .o_axis_TKEEP(k32),
        .o_axis_TLAST(l32), .o_axis_TUSER(u32), .o_rx_frames(f32), .o_rx_errors(e32));

    sakebi_rmii_rx_axis #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .CHECK_FCS(1'b1)) duts (
        .i_rmii_REF_CLK(clk), .i_axis_ARESETn(rst_n), .i_rmii_CRS_DV(crs), .i_rmii_RXD(rxd),
        .o_axis_TVALID(vs), .i_axis_TREADY(rdys), .o_axis_TDATA(ds), .o_axis_TKEEP(ks),
        .o_axis_TLAST(ls), .o_axis_TUSER(us), .o_rx_frames(fs), .o_rx_errors(es));

    beat_t q8[$], q32[$], qs[$];
    logic [7:0] frm[$];
    int cur_extra;
    int checks = 0;
    int errors = 0;
    int expf = 0, expe = 0, expf_s = 0, expe_s = 0;

    // Accepted beats are captured mid-cycle; inputs change 1 ns after posedge.
    always @(negedge clk) begin
        if (v8 && rdy8)   q8.push_back({l8, u8, 4'(k8), 32'(d8)});
        if (v32 && rdy32) q32.push_back({l32, u32, k32, d32});
        if (vs && rdys)   qs.push_back({ls, us, 4'(ks), 32'(ds)});
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fcs_of(input logic [7:0] d[$], input int n);
        logic [31:0] c;
        c = '1;
        for (int i = 0; i < n; i++) begin
            c = c ^ 32'(d[i]);
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    // Frame is bad if trailing dibits leave a partial byte or the last four
    // bytes are not the FCS of the bytes before them.
    function automatic bit frame_err(input logic [7:0] d[$], input int extra);
        int n;
        n = d.size();
        if ((extra % 4) != 0) return 1'b1;
        if (n < 5) return 1'b1;
        return {d[n-1], d[n-2], d[n-3], d[n-4]} != fcs_of(d, n - 4);
    endfunction

    task automatic make_frame(input int n);
        logic [31:0] f;
        frm.delete();
        for (int i = 0; i < n - 4; i++) frm.push_back(8'($urandom_range(0, 255)));
        f = fcs_of(frm, n - 4);
        for (int i = 0; i < 4; i++) frm.push_back(f[8*i +: 8]);
    endtask

    task automatic dibit(input logic c, input logic [1:0] d);
        @(posedge clk); #1;
        crs = c;
        rxd = d;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int k = 0; k < 4; k++) dibit(1'b1, v[2*k +: 2]);
    endtask

    task automatic send_frame(input int extra);
        cur_extra = extra;
        for (int i = 0; i < 7; i++) send_byte(8'h55);
        send_byte(8'hD5);
        foreach (frm[i]) send_byte(frm[i]);
        for (int i = 0; i < extra; i++) dibit(1'b1, 2'($urandom_range(0, 3)));
        repeat (25) dibit(1'b0, 2'b00);
    endtask

    task automatic check_dut(input string tag, input int bpb, input bit err, input beat_t got[$]);
        beat_t exp[$];
        beat_t b;
        int n, cnt;
        n = frm.size();
        for (int i = 0; i < n; i += bpb) begin
            b   = '0;
            cnt = (n - i < bpb) ? (n - i) : bpb;
            for (int j = 0; j < cnt; j++) b.data[8*j +: 8] = frm[i+j];
            b.keep = 4'((1 << cnt) - 1);
            b.last = (i + bpb >= n);
            b.user = b.last && err;
            exp.push_back(b);
        end
        chk({tag, " beats"}, 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            b = got[i];
            if (!b.last) b.user = 1'b0;
            chk($sformatf("%s beat%0d", tag, i), 64'(b), 64'(exp[i]));
        end
    endtask

    task automatic finish_frame(input bit skip_small);
        bit err;
        err = frame_err(frm, cur_extra);
        check_dut("w8", 1, err, q8);
        check_dut("w32", 4, err, q32);
        if (!skip_small) check_dut("s8", 1, err, qs);
        if (frm.size() > 0) begin
            if (err) expe++; else expf++;
            if (!skip_small) begin
                if (err) expe_s++; else expf_s++;
            end
        end
        chk("w8 frames", 64'(f8), 64'(expf));
        chk("w8 errors", 64'(e8), 64'(expe));
        chk("w32 frames", 64'(f32), 64'(expf));
        chk("w32 errors", 64'(e32), 64'(expe));
        chk("s8 frames", 64'(fs), 64'(expf_s));
        chk("s8 errors", 64'(es), 64'(expe_s));
        q8.delete();
        q32.delete();
        if (!skip_small) qs.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " w8 out"},  64'({v8, d8, k8, l8, u8, f8, e8}), 64'(0));
        chk({tag, " w32 out"}, 64'({v32, d32, k32, l32, u32}), 64'(0));
        chk({tag, " w32 cnt"}, 64'({f32, e32}), 64'(0));
        chk({tag, " s8 out"},  64'({vs, ds, ks, ls, us, fs, es}), 64'(0));
    endtask

    initial begin
        rst_n = 1'b1;
        crs   = 1'b0;
        rxd   = 2'b00;
        rdy8  = 1'b1;
        rdy32 = 1'b1;
        rdys  = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (3) dibit(1'b0, 2'b00);

        // 64-byte good frame
        make_frame(64);
        send_frame(0);
        finish_frame(1'b0);

        // 65-byte good frame, then the same frame with one payload bit flipped
        make_frame(65);
        send_frame(0);
        finish_frame(1'b0);
        frm[10] = frm[10] ^ 8'h04;
        send_frame(0);
        finish_frame(1'b0);

        // Three trailing dibits: partial byte dropped, error flagged
        make_frame(30);
        send_frame(3);
        finish_frame(1'b0);

        // SFD followed directly by end of carrier: nothing emitted
        frm.delete();
        send_frame(2);
        finish_frame(1'b0);

        // Random lengths, random corruption / trailing dibits
        for (int r = 0; r < 5; r++) begin
            int n, extra;
            n = $urandom_range(5, 40);
            make_frame(n);
            extra = 0;
            case ($urandom_range(0, 2))
                1: frm[$urandom_range(0, n - 1)] ^= 8'(1 << $urandom_range(0, 7));
                2: extra = $urandom_range(1, 3);
                default: ;
            endcase
            send_frame(extra);
            finish_frame(1'b0);
        end

        // Overflow of the 4-deep FIFO with the sink stalled
        rdys = 1'b0;
        make_frame(20);
        send_frame(0);
        finish_frame(1'b1);
        chk("ovf held none", 64'(qs.size()), 64'(0));
        chk("ovf head", 64'({vs, ds}), 64'({1'b1, frm[0]}));
        rdys = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("ovf beats", 64'(qs.size()), 64'(5));
        for (int i = 0; i < 4 && i < qs.size(); i++)
            chk($sformatf("ovf beat%0d", i), 64'(qs[i]), 64'({1'b0, 1'b0, 4'h1, 32'(frm[i])}));
        if (qs.size() > 4) chk("ovf term", 64'(qs[4]), 64'({1'b1, 1'b1, 4'h0, 32'h0}));
        expe_s++;
        chk("ovf s8 errors", 64'(es), 64'(expe_s));
        chk("ovf s8 frames", 64'(fs), 64'(expf_s));
        qs.delete();
        make_frame(24);
        send_frame(0);
        finish_frame(1'b0);

        // Reset in the middle of frame data, released with carrier still up
        for (int i = 0; i < 7; i++) send_byte(8'h55);
        send_byte(8'hD5);
        for (int i = 0; i < 6; i++) dibit(1'b1, 2'b10);
        rst_n = 1'b0;
        dibit(1'b1, 2'b10);
        dibit(1'b1, 2'b10);
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) dibit(1'b1, 2'b10);
        repeat (25) dibit(1'b0, 2'b00);
        chk("cut w8 beats", 64'(q8.size()), 64'(0));
        chk("cut w32 beats", 64'(q32.size()), 64'(0));
        chk("cut s8 beats", 64'(qs.size()), 64'(0));
        expf = 0; expe = 0; expf_s = 0; expe_s = 0;
        q8.delete(); q32.delete(); qs.delete();
        make_frame(33);
        send_frame(0);
        finish_frame(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
